// File: rtl/edge_pkg.sv
// Shared types for the edge-detection frame scheduler.
// FSM state encoding and ZBT bus widths.
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_RUN    = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  localparam int ZBT_AW = 19;
  localparam int ZBT_DW = 36;

endpackage

// File: rtl/edge_zbt_sched_valid_delay.sv
// Parameterised 1-bit shift line.
// Aligns the edge-valid flag with the Sobel pipeline.
module valid_delay #(
  parameter int DEPTH = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // shift the raw flag one stage per cycle
  always_ff @(posedge clock) begin
    if (reset) sr <= '0;
    else       sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/edge_zbt_sched.sv
// ZBT port arbiter and frame sequencer for the edge path.
// Even slots fetch pixels, odd slots and blanking serve the writer.
module edge_zbt_sched
  import edge_pkg::*;
#(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int FETCH_LEAD = 4,
  parameter int PIPE_LAT   = 6,
  parameter int BORDER     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              blank,
  input  logic              wr_req,
  input  logic [ZBT_AW-1:0] wr_addr,
  input  logic [ZBT_DW-1:0] wr_data,
  output logic              wr_ack,
  output logic [ZBT_AW-1:0] zbt_addr,
  output logic              zbt_we,
  output logic [ZBT_DW-1:0] zbt_wdata,
  output logic              edge_valid,
  output logic              frame_done
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LEAD = 11'(FETCH_LEAD);
  localparam logic [10:0] H_LO   = 11'(BORDER);
  localparam logic [10:0] H_HI   = 11'(H_ACTIVE - BORDER);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_PRM  = 10'(BORDER - 1);
  localparam logic [9:0]  V_HI   = 10'(V_ACTIVE - BORDER);

  state_t      state, state_nx;
  logic        done_nx;
  logic        fetch_en;
  logic [10:0] ha;
  logic        frame_start;
  logic        line_end;
  logic        rd_slot;
  logic        wr_go;
  logic        raw_valid;
  logic        dly_out;

  assign ha          = hcount + H_LEAD;
  assign frame_start = (vcount == '0) && (hcount == '0);
  assign line_end    = (hcount == H_LAST);

  // fetch enable is taken from the next state so the
  // frame-start pixel itself is fetched
  assign rd_slot = fetch_en && !hcount[0] && !blank
                && (ha < H_LIM);

  // a write right after an ack is refused so a held
  // request is never serviced twice
  assign wr_go = !rd_slot && wr_req && !wr_ack
              && (state != ST_IDLE);

  assign raw_valid = (state == ST_RUN) && !blank
                  && (hcount >= H_LO) && (hcount < H_HI)
                  && (vcount < V_HI);

  // frame sequencing: next state, fetch enable, done pulse
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    fetch_en = 1'b0;
    unique case (state)
      ST_IDLE, ST_VBLANK: begin
        if (frame_start) begin
          state_nx = ST_PRIME;
          fetch_en = 1'b1;
        end
      end
      ST_PRIME: begin
        fetch_en = 1'b1;
        if (line_end && vcount == V_PRM)
          state_nx = ST_RUN;
      end
      ST_RUN: begin
        fetch_en = 1'b1;
        if (line_end && vcount == V_LAST) begin
          state_nx = ST_VBLANK;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_vdly (
    .clock (clock),
    .reset (reset),
    .din   (raw_valid),
    .dout  (dly_out)
  );

  // registered ZBT bus, handshake and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      zbt_addr   <= '0;
      zbt_wdata  <= '0;
      zbt_we     <= 1'b0;
      wr_ack     <= 1'b0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      zbt_we     <= wr_go;
      wr_ack     <= wr_go;
      edge_valid <= dly_out;
      frame_done <= done_nx;
      unique case (1'b1)
        rd_slot: zbt_addr <= {vcount, ha[9:1]};
        wr_go: begin
          zbt_addr  <= wr_addr;
          zbt_wdata <= wr_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_zbt_sched.sv
// Scoreboard bench for edge_zbt_sched.
// A per-cycle model queues expected bus state and valid flags.
module tb_edge_zbt_sched;
  import edge_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        blank;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_ack;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic        edge_valid;
  logic        frame_done;

  edge_zbt_sched dut (
    .clock      (clock),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .blank      (blank),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .zbt_addr   (zbt_addr),
    .zbt_we     (zbt_we),
    .zbt_wdata  (zbt_wdata),
    .edge_valid (edge_valid),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic        ack;
    logic        fd;
    logic [18:0] addr;
    logic [35:0] wdata;
  } exp_t;

  exp_t   sbq[$];
  logic   evq[$];
  state_t m_st;
  logic   m_ack;
  logic [18:0] m_addr;
  logic [35:0] m_wd;

  int n_cmp = 0;
  int n_err = 0;
  int nack  = 0;
  int nfd   = 0;
  int nev   = 0;
  int wmode = 0;
  int snap;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic [10:0] h,
                     input logic [9:0] v,
                     input logic b);
    exp_t        e;
    logic [10:0] ha;
    logic        st, rd, wr, raw;
    logic        ev;
    hcount = h;
    vcount = v;
    blank  = b;
    e = '0;
    if (reset) begin
      m_st   = ST_IDLE;
      m_ack  = 1'b0;
      m_addr = '0;
      m_wd   = '0;
      evq.delete();
      repeat (7) evq.push_back(1'b0);
    end else begin
      st = (v == 10'd0) && (h == 11'd0);
      ha = h + 11'd4;
      rd = !h[0] && !b && (ha < 11'd1024)
        && (m_st == ST_PRIME || m_st == ST_RUN
            || (st && (m_st == ST_IDLE
                       || m_st == ST_VBLANK)));
      wr = !rd && wr_req && !m_ack
        && (m_st != ST_IDLE);
      raw = (m_st == ST_RUN) && !b
         && (h >= 11'd2) && (h < 11'd1022)
         && (v < 10'd766);
      if (rd) m_addr = {v, ha[9:1]};
      else if (wr) begin
        m_addr = wr_addr;
        m_wd   = wr_data;
      end
      e.we    = wr;
      e.ack   = wr;
      e.addr  = m_addr;
      e.wdata = m_wd;
      case (m_st)
        ST_IDLE, ST_VBLANK:
          if (st) m_st = ST_PRIME;
        ST_PRIME:
          if (v == 10'd1 && h == 11'd1023) m_st = ST_RUN;
        ST_RUN:
          if (v == 10'd767 && h == 11'd1023) begin
            m_st = ST_VBLANK;
            e.fd = 1'b1;
          end
        default: m_st = ST_IDLE;
      endcase
      m_ack = wr;
      evq.push_back(raw);
    end
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e  = sbq.pop_front();
    ev = evq.pop_front();
    check("zbt_we", 64'(zbt_we), 64'(e.we));
    check("wr_ack", 64'(wr_ack), 64'(e.ack));
    check("zbt_addr", 64'(zbt_addr), 64'(e.addr));
    check("zbt_wdata", 64'(zbt_wdata), 64'(e.wdata));
    check("frame_done", 64'(frame_done), 64'(e.fd));
    check("edge_valid", 64'(edge_valid), 64'(ev));
    if (frame_done) nfd++;
    if (edge_valid) nev++;
    if (wr_ack) begin
      nack++;
      if (wmode == 1) wr_req = 1'b0;
      else if (wmode == 2) begin
        wr_addr = wr_addr + 19'd1;
        wr_data = {4'h5, $urandom};
      end
    end
  endtask

  task automatic line(input int v, input int h0,
                      input int h1);
    for (int h = h0; h <= h1; h++)
      cyc(11'(h), 10'(v), (h >= 1024) || (v >= 768));
  endtask

  initial begin
    reset   = 1'b1;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    cyc(11'd1030, 10'd767, 1'b1);
    cyc(11'd1031, 10'd767, 1'b1);
    reset = 1'b0;

    wr_req  = 1'b1;
    wr_addr = 19'h00007;
    wr_data = 36'h0_0000_0077;
    line(767, 1032, 1045);
    check("idle_no_ack", 64'(nack), 64'd0);
    wr_req = 1'b0;

    cyc(11'd0, 10'd0, 1'b0);
    check("st_prime", 64'(dut.state), 64'(ST_PRIME));
    check("first_rd", 64'(zbt_addr), 64'd2);
    check("first_we", 64'(zbt_we), 64'd0);
    line(0, 1, 9);
    wr_req  = 1'b1;
    wr_addr = 19'h01234;
    wr_data = 36'h9_ABCD_1234;
    wmode   = 1;
    nev     = 0;
    line(0, 10, 1099);
    check("line0_acks", 64'(nack), 64'd1);
    line(1, 0, 1099);
    check("st_run", 64'(dut.state), 64'(ST_RUN));
    check("ev_lines01", 64'(nev), 64'd0);

    for (int v = 2; v <= 4; v++) line(v, 0, 1099);
    nev = 0;
    line(5, 0, 1099);
    check("ev_line5", 64'(nev), 64'd1020);

    line(765, 0, 1099);
    nev = 0;
    line(766, 0, 1099);
    line(767, 0, 1099);
    check("ev_bottom", 64'(nev), 64'd0);
    check("fd_once", 64'(nfd), 64'd1);
    check("st_vblank", 64'(dut.state), 64'(ST_VBLANK));

    snap    = nack;
    wmode   = 2;
    wr_req  = 1'b1;
    wr_addr = 19'h40000;
    wr_data = 36'h1_0000_0001;
    line(768, 0, 39);
    check("storm_acks", 64'(nack - snap), 64'd20);
    wr_req = 1'b0;
    wmode  = 0;
    line(769, 0, 9);
    check("fd_still_once", 64'(nfd), 64'd1);

    line(0, 0, 1099);
    line(1, 0, 1099);
    line(2, 0, 499);
    wr_req  = 1'b1;
    wr_addr = 19'h2BEEF;
    wr_data = 36'h3_2222_1111;
    reset   = 1'b1;
    cyc(11'd500, 10'd2, 1'b0);
    reset = 1'b0;
    check("rst_flags",
          64'({zbt_we, wr_ack, edge_valid, frame_done}),
          64'd0);
    check("rst_addr", 64'(zbt_addr), 64'd0);
    check("rst_st", 64'(dut.state), 64'(ST_IDLE));
    snap = nack;
    line(2, 501, 1099);
    line(3, 0, 1099);
    check("rst_no_ack", 64'(nack - snap), 64'd0);
    wmode = 1;
    line(0, 0, 3);
    check("resume_ack", 64'(nack - snap), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
